// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall patterns, exception codes,
// Stop/Flush levels, FSM state type and the stall-priority encoder.
package pipe_ctrl_pkg;

  // Stall vector bit order: 0=pc 1=if 2=id 3=ex 4=mem 5=wb
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;
  localparam logic FLUSH    = 1'b1;
  localparam logic NO_FLUSH = 1'b0;

  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_INST    = 32'hA;
  localparam logic [31:0] EXC_OV      = 32'hC;
  localparam logic [31:0] EXC_TRAP    = 32'hD;
  localparam logic [31:0] EXC_ERET    = 32'hE;

  // Perf counter indices, matching perf_sel
  localparam int PERF_IF  = 0;
  localparam int PERF_ID  = 1;
  localparam int PERF_EX  = 2;
  localparam int PERF_MEM = 3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Deepest requester wins: a stalled stage freezes everything upstream.
  function automatic logic [5:0] stall_pattern(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: stall requests and exception info in from the
// pipeline, stall/flush/redirect and perf readout back out.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [1:0]  perf_sel;
  logic [31:0] perf_cnt;

  // Pipeline side: raises requests, consumes controls
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype, cp0_epc, perf_sel,
    input  stall, flush, new_pc, stall_timeout, perf_cnt
  );

  // Controller side
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype, cp0_epc, perf_sel,
    output stall, flush, new_pc, stall_timeout, perf_cnt
  );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles (saturating at
// STALL_LIMIT) and raises a sticky timeout once the limit is reached.
module stall_watchdog #(
  parameter int STALL_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic timeout
);
  localparam int W = $clog2(STALL_LIMIT + 1);
  localparam logic [W-1:0] LIMIT   = W'(STALL_LIMIT);
  localparam logic [W-1:0] LIMIT_M = W'(STALL_LIMIT - 1);

  logic [W-1:0] scnt;
  logic         flag;

  // Count run length of stalls; flag is set on the edge where scnt
  // reaches the limit so it is visible the following cycle, and holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      flag <= 1'b0;
    end else begin
      if (!stalled)          scnt <= '0;
      else if (scnt != LIMIT) scnt <= scnt + 1'b1;
      if (stalled && scnt >= LIMIT_M) flag <= 1'b1;
    end
  end

  assign timeout = flag;
endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merge, exception/ERET flush
// sequencing with bus-stall deferral (PEND) and post-flush hold-off
// (HOLD), stall watchdog. Optional stall perf counters are built when
// PIPE_CTRL_PERF_EN is defined; otherwise perf_cnt reads 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter int          FLUSH_HOLD  = 2,
  parameter int          STALL_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  state_t      state;
  logic [3:0]  hold_cnt;
  logic [31:0] exc_q;
  logic [31:0] epc_q;

  logic [5:0]  req_stall;
  logic [5:0]  stall_w;
  logic        flush_w;
  logic [31:0] new_pc_w;
  logic        go_pend;
  logic        timeout;

  assign req_stall = stall_pattern(bus.stallreq_if, bus.stallreq_id,
                                   bus.stallreq_ex, bus.stallreq_mem);

  // Output decode from state and live inputs; a flush always clears stall.
  always_comb begin
    stall_w  = req_stall;
    flush_w  = NO_FLUSH;
    new_pc_w = 32'h0;
    go_pend  = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.excepttype != EXC_NONE) begin
          if (bus.stallreq_mem) begin
            stall_w = STALL_MEM;
            go_pend = 1'b1;
          end else begin
            stall_w  = STALL_NONE;
            flush_w  = FLUSH;
            new_pc_w = (bus.excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
          end
        end
      end
      ST_PEND: begin
        if (bus.stallreq_mem) begin
          stall_w = STALL_MEM;
        end else begin
          stall_w  = STALL_NONE;
          flush_w  = FLUSH;
          new_pc_w = (exc_q == EXC_ERET) ? epc_q : EXC_VECTOR;
        end
      end
      default: ;
    endcase
    if (rst) begin
      stall_w  = STALL_NONE;
      flush_w  = NO_FLUSH;
      new_pc_w = 32'h0;
      go_pend  = 1'b0;
    end
  end

  // Exception sequencer: defer under data-bus stall, then hold off new
  // exceptions for FLUSH_HOLD cycles after each flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      hold_cnt <= 4'd0;
      exc_q    <= 32'h0;
      epc_q    <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (go_pend) begin
            state <= ST_PEND;
            exc_q <= bus.excepttype;
            epc_q <= bus.cp0_epc;
          end else if (flush_w) begin
            state    <= (FLUSH_HOLD == 0) ? ST_RUN : ST_HOLD;
            hold_cnt <= 4'(FLUSH_HOLD - 1);
          end
        end
        ST_PEND: begin
          if (flush_w) begin
            state    <= (FLUSH_HOLD == 0) ? ST_RUN : ST_HOLD;
            hold_cnt <= 4'(FLUSH_HOLD - 1);
            exc_q    <= 32'h0;
            epc_q    <= 32'h0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 4'd0) state <= ST_RUN;
          else                  hold_cnt <= hold_cnt - 4'd1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  stall_watchdog #(.STALL_LIMIT(STALL_LIMIT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stalled (stall_w != STALL_NONE),
    .timeout (timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [3:0]       win;
  logic [3:0][31:0] perf_q;

  assign win[PERF_MEM] = bus.stallreq_mem;
  assign win[PERF_EX]  = bus.stallreq_ex & ~bus.stallreq_mem;
  assign win[PERF_ID]  = bus.stallreq_id & ~bus.stallreq_ex & ~bus.stallreq_mem;
  assign win[PERF_IF]  = bus.stallreq_if & ~bus.stallreq_id & ~bus.stallreq_ex
                         & ~bus.stallreq_mem;

  // Per-source stall cycle counters; flush cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (!flush_w) begin
      for (int i = 0; i < 4; i++)
        if (win[i]) perf_q[i] <= perf_q[i] + 32'd1;
    end
  end

  assign bus.perf_cnt = rst ? 32'h0 : perf_q[bus.perf_sel];
`else
  logic [1:0] unused_perf_sel;
  assign unused_perf_sel = bus.perf_sel;
  assign bus.perf_cnt    = 32'h0;
`endif

  assign bus.stall         = stall_w;
  assign bus.flush         = flush_w;
  assign bus.new_pc        = new_pc_w;
  assign bus.stall_timeout = rst ? 1'b0 : timeout;

endmodule
